// File: rtl/charlieplex_pkg.sv
// Shared definitions for the charlieplex PWM framebuffer: brightness width default,
// pixel-index width helper and FSM state encoding.
package charlieplex_pkg;

  localparam int BRIGHT_BITS_DEFAULT = 4;

  localparam logic [0:0] ST_ACCEPT  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/charlieplex_pwm_timebase.sv
// PWM timebase: prescaler of SCAN_DIV clocks per step, 2**BRIGHTBITS-1 steps per period.
// boundary is high during the last cycle of a period (its edge starts the next one).
module charlieplex_pwm_timebase #(
  parameter int SCAN_DIV   = 12,
  parameter int BRIGHTBITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [BRIGHTBITS-1:0] step,
  output logic                  boundary
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]         PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [BRIGHTBITS-1:0] STEP_LAST = BRIGHTBITS'((1 << BRIGHTBITS) - 2);

  logic [PW-1:0] prescaler;
  logic          pre_wrap;

  assign pre_wrap = (prescaler == PRE_LAST);
  assign boundary = pre_wrap && (step == STEP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      step      <= '0;
    end else begin
      prescaler <= pre_wrap ? '0 : prescaler + 1'b1;
      if (pre_wrap) step <= (step == STEP_LAST) ? '0 : step + 1'b1;
    end
  end

endmodule

// File: rtl/charlieplex_pwm_framebuffer.sv
// Double-buffered PWM framebuffer: pixelstate registered 1 clk after front/step; wr_ready drops
// while a commit waits for the period boundary. CHARLIEPLEX_GAMMA_EN enables square-law write gamma.
module charlieplex_pwm_framebuffer
  import charlieplex_pkg::*;
#(
  parameter int PIXELCOUNT = 12,
  parameter int BRIGHTBITS = BRIGHT_BITS_DEFAULT,
  parameter int SCAN_DIV   = 12
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [idx_width(PIXELCOUNT)-1:0]    wr_addr,
  input  logic [BRIGHTBITS-1:0]               wr_data,
  input  logic                                commit,
  output logic                                busy,
  output logic                                period_start,
  output logic [PIXELCOUNT-1:0]               pixelstate
);
  localparam int AW = idx_width(PIXELCOUNT);
  localparam logic [AW:0] PIX_LIMIT = (AW + 1)'(PIXELCOUNT);

  logic [0:0]            state;
  logic                  first_cycle;
  logic [BRIGHTBITS-1:0] step;
  logic                  boundary;
  logic [BRIGHTBITS-1:0] store_data;
  logic [BRIGHTBITS-1:0] front [PIXELCOUNT];
  logic [BRIGHTBITS-1:0] back  [PIXELCOUNT];

  charlieplex_pwm_timebase #(
    .SCAN_DIV   (SCAN_DIV),
    .BRIGHTBITS (BRIGHTBITS)
  ) u_timebase (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
    .boundary (boundary)
  );

`ifdef CHARLIEPLEX_GAMMA_EN
  localparam int GW = 2 * BRIGHTBITS + 1;
  // Rounding by 2**B-1 is a true ceiling, so 1 and full scale map onto themselves.
  localparam logic [GW-1:0] ROUND = GW'((1 << BRIGHTBITS) - 1);
  localparam logic [GW-1:0] MAXV  = GW'((1 << BRIGHTBITS) - 1);
  logic [2*BRIGHTBITS-1:0] sq;
  logic [GW-1:0]           scaled;

  always_comb begin
    sq         = {{BRIGHTBITS{1'b0}}, wr_data} * {{BRIGHTBITS{1'b0}}, wr_data};
    scaled     = ({1'b0, sq} + ROUND) >> BRIGHTBITS;
    store_data = (scaled > MAXV) ? '1 : scaled[BRIGHTBITS-1:0];
  end
`else
  assign store_data = wr_data;
`endif

  assign wr_ready = (state == ST_ACCEPT);
  assign busy     = (state == ST_PENDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_ACCEPT;
      first_cycle  <= 1'b1;
      period_start <= 1'b0;
      pixelstate   <= '0;
      for (int i = 0; i < PIXELCOUNT; i++) begin
        front[i] <= '0;
        back[i]  <= '0;
      end
    end else begin
      first_cycle  <= 1'b0;
      period_start <= first_cycle | boundary;
      for (int i = 0; i < PIXELCOUNT; i++) pixelstate[i] <= (front[i] > step);

      if (state == ST_ACCEPT) begin
        // Out-of-range addresses still handshake; their data is dropped.
        if (wr_valid && ({1'b0, wr_addr} < PIX_LIMIT)) back[wr_addr] <= store_data;
        if (commit) state <= ST_PENDING;
      end else if (boundary) begin
        for (int i = 0; i < PIXELCOUNT; i++) front[i] <= back[i];
        state <= ST_ACCEPT;
      end
    end
  end

endmodule

// File: tb/tb_charlieplex_pwm_framebuffer.sv
// Scoreboard bench: stimulus queues per-period lit-cycle counts, a negedge monitor
// accumulates pixelstate over each PWM period and compares on every period_start.
module tb_charlieplex_pwm_framebuffer;
  localparam int NPIX = 12;
  typedef logic [NPIX-1:0][7:0] win_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [3:0]      wr_addr = 4'd0;
  logic [3:0]      wr_data = 4'd0;
  logic            commit = 1'b0;
  logic            busy;
  logic            period_start;
  logic [NPIX-1:0] pixelstate;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  win_t exp_q[$];
  win_t acc;
  bit   win_open = 1'b0;
  bit   ps_seen  = 1'b0;
  int   win_idx  = 0;

  charlieplex_pwm_framebuffer #(
    .PIXELCOUNT (NPIX),
    .BRIGHTBITS (4),
    .SCAN_DIV   (12)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .commit       (commit),
    .busy         (busy),
    .period_start (period_start),
    .pixelstate   (pixelstate)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int lvl(input int d);
`ifdef CHARLIEPLEX_GAMMA_EN
    case (d)
      0:       return 0;
      1:       return 1;
      2:       return 1;
      8:       return 4;
      15:      return 15;
      default: return 0;
    endcase
`else
    return d;
`endif
  endfunction

  // Lit cycles per period = stored level * 12 clocks per step.
  function automatic win_t mkwin(input int b0, input int b3, input int b5, input int b7);
    win_t w;
    w    = '0;
    w[0] = 8'(lvl(b0) * 12);
    w[3] = 8'(lvl(b3) * 12);
    w[5] = 8'(lvl(b5) * 12);
    w[7] = 8'(lvl(b7) * 12);
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic close_window();
    win_t e;
    int   bad;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL window%0d: period completed with no expectation queued", win_idx);
    end else begin
      e   = exp_q.pop_front();
      bad = -1;
      for (int i = NPIX - 1; i >= 0; i--) if (acc[i] !== e[i]) bad = i;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL window%0d px%0d: lit %0d cycles, expected %0d", win_idx, bad, acc[bad], e[bad]);
      end
    end
    win_idx++;
  endtask

  // Monitor: a period's window opens the cycle after period_start (pixelstate lags by one clk).
  always @(negedge clk) begin
    if (!rst_n) begin
      win_open = 1'b0;
      ps_seen  = 1'b0;
      acc      = '0;
    end else begin
      if (ps_seen) begin
        if (win_open) close_window();
        win_open = 1'b1;
        acc      = '0;
      end
      if (win_open)
        for (int i = 0; i < NPIX; i++) if (pixelstate[i]) acc[i] = acc[i] + 8'd1;
      ps_seen = period_start;
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_valid = 1'b1;
    wr_addr  = a[3:0];
    wr_data  = d[3:0];
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(posedge clk);
    #1;
    commit = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cyc %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_q.push_back(mkwin(0, 0, 0, 0));
    exp_q.push_back(mkwin(0, 15, 0, 8));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pixelstate", 32'(pixelstate), 0);
    chk("rst_wr_ready", 32'(wr_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_period_start", 32'(period_start), 0);
    rst_n = 1'b1;

    wait_cyc(1);   chk("period_start_first", 32'(period_start), 1);
    wait_cyc(2);   chk("period_start_drop", 32'(period_start), 0);
    wait_cyc(5);
    wr(3, 15); wr(5, 0); wr(7, 8);
    pulse_commit();
    chk("pending_busy", 32'(busy), 1);
    chk("pending_wr_ready", 32'(wr_ready), 0);
    wait_cyc(179); chk("busy_before_boundary", 32'(busy), 1);
    chk("no_early_period_start", 32'(period_start), 0);
    wait_cyc(180); chk("busy_after_swap", 32'(busy), 0);
    chk("wr_ready_after_swap", 32'(wr_ready), 1);
    chk("period_start_boundary", 32'(period_start), 1);

    // Mid-period commit, ignored write and second commit while pending.
    exp_q.push_back(mkwin(1, 15, 0, 2));
    wait_cyc(182); wr(0, 1); wr(7, 2);
    wait_cyc(189); pulse_commit();
    chk("midperiod_busy", 32'(busy), 1);
    wait_cyc(250);
    wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 4'd0; commit = 1'b1;
    @(posedge clk);
    #1;
    chk("pending_blocks_write", 32'(wr_ready), 0);
    wr_valid = 1'b0; commit = 1'b0;
    wait_cyc(359); chk("busy_until_boundary", 32'(busy), 1);
    wait_cyc(361); chk("no_queued_commit", 32'(busy), 0);

    // Out-of-range write is accepted but changes nothing.
    exp_q.push_back(mkwin(1, 15, 0, 2));
    wait_cyc(365); chk("ready_for_oob", 32'(wr_ready), 1);
    wr(12, 15);
    pulse_commit();

    // Commit on the boundary edge swaps only at the following boundary.
    exp_q.push_back(mkwin(1, 15, 0, 2));
    exp_q.push_back(mkwin(1, 15, 15, 2));
    wait_cyc(545); wr(5, 15);
    wait_cyc(719); pulse_commit();
    chk("boundary_commit_pending", 32'(busy), 1);
    wait_cyc(899); chk("boundary_commit_held", 32'(busy), 1);
    wait_cyc(900); chk("boundary_commit_swapped", 32'(busy), 0);

    // Reset while pending discards the swap.
    wait_cyc(1090); wr(1, 15);
    pulse_commit();
    chk("pre_reset_busy", 32'(busy), 1);
    wait_cyc(1150);
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_wr_ready", 32'(wr_ready), 1);
    chk("midreset_pixelstate", 32'(pixelstate), 0);
    exp_q.push_back(mkwin(0, 0, 0, 0));
    exp_q.push_back(mkwin(0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_cyc(181); chk("post_reset_busy", 32'(busy), 0);
    wait_cyc(365);
    chk("all_periods_checked", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
